// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with a one-word holding buffer so that
// consecutive frames go out back-to-back without an idle gap.
module uart_tx_frame #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk100_i,
    input  logic                 rstn_i,
    input  logic                 start_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 tx_o
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W  = 4;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0]  STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                 state, state_n;
    logic [BAUD_W-1:0]      baud, baud_n;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [DATA_BITS-1:0]   shreg, shreg_n;
    logic                   par_bit, par_n;
    logic [DATA_BITS-1:0]   hold, hold_n;
    logic                   hold_full, hold_full_n;
    logic                   tx_n, busy_n, ready_n, done_n;
    logic                   accept, bit_end;

    // Parity bit for a whole word, computed once when the word is loaded.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state     <= S_IDLE;
            baud      <= '0;
            idx       <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            tx_o      <= 1'b1;
            busy_o    <= 1'b0;
            ready_o   <= 1'b1;
            done_o    <= 1'b0;
        end else begin
            state     <= state_n;
            baud      <= baud_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            par_bit   <= par_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            tx_o      <= tx_n;
            busy_o    <= busy_n;
            ready_o   <= ready_n;
            done_o    <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        baud_n      = baud;
        idx_n       = idx;
        shreg_n     = shreg;
        par_n       = par_bit;
        hold_n      = hold;
        hold_full_n = hold_full;

        accept  = start_i && !hold_full;
        bit_end = (baud == BAUD_LAST);

        if (state != S_IDLE) begin
            baud_n = bit_end ? '0 : baud + BAUD_W'(1);
        end

        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    shreg_n = data_i;
                    par_n   = parity_of(data_i);
                    baud_n  = '0;
                    idx_n   = '0;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    idx_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (idx == DATA_LAST) begin
                        idx_n   = '0;
                        state_n = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    idx_n   = '0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (idx == STOP_LAST) begin
                        idx_n = '0;
                        // Chain straight into the buffered word to avoid an idle gap.
                        if (hold_full) begin
                            shreg_n     = hold;
                            par_n       = parity_of(hold);
                            hold_full_n = 1'b0;
                            state_n     = S_START;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // A request arriving mid-frame lands in the holding buffer; a refill
        // on the draining edge wins over the drain's empty marking.
        if (accept && (state != S_IDLE)) begin
            hold_n      = data_i;
            hold_full_n = 1'b1;
        end

        unique case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            S_PAR:   tx_n = par_n;
            default: tx_n = 1'b1;
        endcase

        busy_n  = (state_n != S_IDLE) || hold_full_n;
        ready_n = !hold_full_n;
        done_n  = (state_n == S_STOP) && (baud_n == BAUD_LAST) && (idx_n == STOP_LAST);
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations (8N1, 8E1, 8O1, 7N2) at four
// clocks per bit, with a frame scoreboard and a per-cycle line monitor.
module tb_uart_tx_frame;

    localparam int unsigned CPB = 4;

    typedef struct {
        int          inst;
        logic [15:0] bits;
    } frame_t;

    logic       clk;
    logic       rstn;
    logic [3:0] start_v;
    logic [7:0] d_bus;
    logic [3:0] ready_v, busy_v, done_v, tx_v;

    int checks = 0;
    int errors = 0;

    frame_t      exp_q[$];
    logic [3:0]  act = '0;
    int          cnt[4];
    logic [15:0] cur[4];
    int          len[4];

    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk100_i(clk), .rstn_i(rstn), .start_i(start_v[0]), .data_i(d_bus[7:0]),
        .ready_o(ready_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]), .tx_o(tx_v[0]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk100_i(clk), .rstn_i(rstn), .start_i(start_v[1]), .data_i(d_bus[7:0]),
        .ready_o(ready_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]), .tx_o(tx_v[1]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u2 (
        .clk100_i(clk), .rstn_i(rstn), .start_i(start_v[2]), .data_i(d_bus[7:0]),
        .ready_o(ready_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]), .tx_o(tx_v[2]));
    uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u3 (
        .clk100_i(clk), .rstn_i(rstn), .start_i(start_v[3]), .data_i(d_bus[6:0]),
        .ready_o(ready_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]), .tx_o(tx_v[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int cfg_db(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction

    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int flen(input int i);
        return 1 + cfg_db(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_sb(i);
    endfunction

    // Expected line levels, one per bit time, first bit in position 0.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int i);
        logic [15:0] f;
        int          k;
        int          ones;
        f    = '1;
        f[0] = 1'b0;
        ones = 0;
        k    = 1;
        for (int j = 0; j < cfg_db(i); j++) begin
            f[k] = d[j];
            ones += int'(d[j]);
            k++;
        end
        if (cfg_par(i) == 2) f[k] = (ones % 2) == 1;
        if (cfg_par(i) == 1) f[k] = (ones % 2) == 0;
        return f;
    endfunction

    task automatic send(input int i, input logic [7:0] d, input logic acc);
        frame_t f;
        check($sformatf("ready_u%0d", i), 32'(ready_v[i]), 32'(acc));
        if (acc) begin
            f.inst = i;
            f.bits = frame_bits(d, i);
            exp_q.push_back(f);
        end
        d_bus      = d;
        start_v[i] = 1'b1;
        @(posedge clk);
        #1;
        start_v[i] = 1'b0;
        d_bus      = ~d;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 600; k++) begin
            if (exp_q.size() == 0 && act == 4'b0) break;
            @(posedge clk);
            #1;
        end
        check("idle_reached", 32'(exp_q.size() == 0 && act == 4'b0), 32'd1);
    endtask

    // Line monitor: follows each frame cycle by cycle against the scoreboard.
    always @(negedge clk) begin
        if (!rstn) begin
            act <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                logic        a;
                int          c;
                logic [15:0] b;
                int          n;
                int          owner;
                frame_t      f;
                a = act[i];
                c = cnt[i];
                b = cur[i];
                n = len[i];
                if (!a && tx_v[i] == 1'b0) begin
                    a     = 1'b1;
                    c     = 0;
                    n     = flen(i);
                    b     = '1;
                    owner = (exp_q.size() != 0) ? exp_q[0].inst : 99;
                    check($sformatf("frame_owner_u%0d", i), 32'(owner), 32'(i));
                    if (owner == i) begin
                        f = exp_q.pop_front();
                        b = f.bits;
                    end
                end
                if (a) begin
                    check($sformatf("tx_u%0d_c%0d", i, c), 32'(tx_v[i]), 32'(b[c / CPB]));
                    check($sformatf("done_u%0d_c%0d", i, c), 32'(done_v[i]),
                          32'(c == n * CPB - 1));
                    if (c == n * CPB - 1) a = 1'b0;
                    else c++;
                end else begin
                    check($sformatf("done_idle_u%0d", i), 32'(done_v[i]), 32'd0);
                end
                act[i] <= a;
                cnt[i] <= c;
                cur[i] <= b;
                len[i] <= n;
            end
        end
    end

    initial begin
        rstn    = 1'b0;
        start_v = '0;
        d_bus   = '0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rst_tx", 32'(tx_v), 32'hF);
        check("rst_busy", 32'(busy_v), 32'h0);
        check("rst_ready", 32'(ready_v), 32'hF);
        check("rst_done", 32'(done_v), 32'h0);

        // 8N1 single frame with F0
        send(0, 8'hF0, 1'b1);
        check("t1_tx_start", 32'(tx_v[0]), 32'd0);
        check("t1_busy", 32'(busy_v[0]), 32'd1);
        repeat (39) @(posedge clk);
        #1;
        check("t1_done_c40", 32'(done_v[0]), 32'd1);
        @(posedge clk);
        #1;
        check("t1_done_c41", 32'(done_v[0]), 32'd0);
        check("t1_busy_c41", 32'(busy_v[0]), 32'd0);
        wait_idle();

        // Parity bit sits in cycles 37..40 of an 8-bit frame
        send(1, 8'hF0, 1'b1);
        repeat (36) @(posedge clk);
        #1;
        check("even_F0_par", 32'(tx_v[1]), 32'd0);
        repeat (7) @(posedge clk);
        #1;
        check("even_done_c44", 32'(done_v[1]), 32'd1);
        wait_idle();
        send(1, 8'h07, 1'b1);
        repeat (36) @(posedge clk);
        #1;
        check("even_07_par", 32'(tx_v[1]), 32'd1);
        wait_idle();
        send(2, 8'h07, 1'b1);
        repeat (36) @(posedge clk);
        #1;
        check("odd_07_par", 32'(tx_v[2]), 32'd0);
        wait_idle();

        // Back-to-back with an overflow attempt
        send(0, 8'hA5, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(0, 8'h3C, 1'b1);
        check("b2b_ready_c6", 32'(ready_v[0]), 32'd0);
        check("b2b_busy_c6", 32'(busy_v[0]), 32'd1);
        send(0, 8'hFF, 1'b0);
        repeat (33) @(posedge clk);
        #1;
        check("b2b_done1_c40", 32'(done_v[0]), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_start2_c41", 32'(tx_v[0]), 32'd0);
        check("b2b_ready_c41", 32'(ready_v[0]), 32'd1);
        repeat (39) @(posedge clk);
        #1;
        check("b2b_done2_c80", 32'(done_v[0]), 32'd1);
        @(posedge clk);
        #1;
        check("b2b_busy_c81", 32'(busy_v[0]), 32'd0);
        wait_idle();

        // 7N2 with 55
        send(3, 8'h55, 1'b1);
        repeat (39) @(posedge clk);
        #1;
        check("7n2_done_c40", 32'(done_v[3]), 32'd1);
        wait_idle();

        // Reset during DATA bit 3 with a word buffered
        send(0, 8'h5A, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        send(0, 8'hC3, 1'b1);
        repeat (14) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        check("rst_mid_tx", 32'(tx_v[0]), 32'd1);
        check("rst_mid_busy", 32'(busy_v[0]), 32'd0);
        check("rst_mid_ready", 32'(ready_v[0]), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("post_rst_tx", 32'(tx_v[0]), 32'd1);
        check("post_rst_busy", 32'(busy_v[0]), 32'd0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. Serialises one word per accepted request onto tx_o. Data width, parity mode, stop-bit count and baud divisor are configurable. A one-entry holding buffer accepts the next word while the current frame is on the line, so frames go out back-to-back with no idle gap. Sits between the byte producer (core logic or a FIFO) and the board UART pin on the 100 MHz domain.

Parameters:
CLKS_PER_BIT, 868, clk100_i cycles per bit (100 MHz / 115200 baud); legal range ≥2
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2

Ports:
clk100_i  input  1  system clock, 100 MHz, rising edge
rstn_i  input  1  asynchronous active-low reset
start_i  input  1  request; sampled each rising edge; accepted when start_i=1 and ready_o=1
data_i  input  DATA_BITS  payload; captured on the accepting edge
ready_o  output  1  1 = holding buffer empty, request will be accepted
busy_o  output  1  1 = frame in progress or word pending
done_o  output  1  one-cycle pulse in the last cycle of each frame's final stop bit
tx_o  output  1  serial line; idles high

Behaviour:
- Reset (async assert, sync release): tx_o=1, busy_o=0, ready_o=1, done_o=0, FSM=IDLE, buffer empty, counters 0. Asserting reset mid-frame forces tx_o=1 immediately and discards the current frame and any buffered word.
- FSM states: IDLE, START, DATA, PAR, STOP. Every non-IDLE state holds each bit for exactly CLKS_PER_BIT cycles, counted by a baud counter from 0 to CLKS_PER_BIT-1.
- IDLE: tx_o=1. An accepted request loads the shift register directly, with the buffer untouched, and moves to START. tx_o goes 0 and busy_o goes 1 on the cycle after the accepting edge.
- START: tx_o=0 for one bit time, then DATA.
- DATA: drives data LSB first. The bit index runs 0..DATA_BITS-1. After the last bit, go to PAR if PARITY!=0, else STOP.
- PAR: even parity drives XOR of the data bits; odd parity drives its inverse. The data bits plus the parity bit then have an even (or odd) number of ones.
- STOP: tx_o=1 for STOP_BITS bit times. done_o pulses in the final cycle.
  - At that final cycle, if the buffer is full: load the buffer into the shift register, mark the buffer empty, and go to START. The next start bit begins on the following cycle, with no idle cycle.
  - Otherwise go to IDLE; busy_o drops on the cycle after done_o.
- Holding buffer, one entry:
  - ready_o = buffer empty.
  - While not IDLE, an accepted request writes data_i to the buffer, and ready_o goes 0 on the next cycle.
  - start_i while ready_o=0 is ignored; no state changes.
- Simultaneous events: an accept on the same edge the buffer is drained into the shift register is legal. The buffer is refilled and ready_o stays 0. The FSM transition takes priority, and the new word is not lost.
- Frame length in cycles: CLKS_PER_BIT × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- data_i changes after the accepting edge have no effect on the frame in flight.
- busy_o = (FSM != IDLE) or buffer full.

Test Plan:
- 8N1, CLKS_PER_BIT=4, after reset: assert start_i one cycle with data_i=8'hF0.
  - tx_o per bit = 0, 0,0,0,0, 1,1,1,1, 1, with each level held 4 cycles (40 cycles total).
  - done_o pulses once at cycle 40 after accept; busy_o is 0 the cycle after.
- Parity, 8-bit, CLKS_PER_BIT=4:
  - PARITY=2 with 8'hF0 → parity bit 0; PARITY=2 with 8'h07 → parity bit 1; PARITY=1 with 8'h07 → parity bit 0.
  - Frame = 44 cycles.
- Back-to-back: send 8'hA5, then 8'h3C at cycle 5 while busy.
  - ready_o drops at cycle 6.
  - The second start bit immediately follows the first stop bit, with no high gap beyond the stop bit.
  - done_o pulses exactly 40 cycles apart.
- Overflow: with the buffer holding 8'h3C, pulse start_i with 8'hFF.
  - It is ignored; only 8'hA5 and 8'h3C appear on tx_o.
- DATA_BITS=7, STOP_BITS=2, PARITY=0, data 7'h55:
  - tx_o bits = 0,1,0,1,0,1,0,1,1,1; frame = 40 cycles at CLKS_PER_BIT=4.
- Reset mid-frame: assert rstn_i=0 during DATA bit 3 with a word buffered.
  - tx_o=1, busy_o=0, ready_o=1 without waiting for a clock edge.
  - After release, no residual frame is transmitted.
